// File: rtl/gpu_pkg.sv
// Shared encodings for the GPU core: scheduler states, write-back source
// select and the read-only special register map of a thread register file.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    REG_SRC_ALU  = 2'b00,
    REG_SRC_LSU  = 2'b01,
    REG_SRC_IMM  = 2'b10,
    REG_SRC_RSVD = 2'b11
  } reg_src_e;

  localparam int NUM_REGS      = 16;
  localparam int GP_REG_LIMIT  = 13;  // R0..R12 are writable
  localparam int REG_BLOCK_ID  = 13;
  localparam int REG_BLOCK_DIM = 14;
  localparam int REG_THREAD_ID = 15;

endpackage : gpu_pkg

// File: rtl/thread_register_file.sv
// Per-thread register file: 13 general-purpose registers plus read-only
// block id / block dim / thread id, read in REQUEST and written in UPDATE.
module thread_register_file
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);

  core_state_e          w_state;
  reg_src_e             w_src;
  logic                 w_write_en;
  logic [DATA_BITS-1:0] w_write_data;

  logic [DATA_BITS-1:0] r_regs [NUM_REGS];
  logic [DATA_BITS-1:0] r_rs;
  logic [DATA_BITS-1:0] r_rt;

  assign w_state = core_state_e'(core_state);
  assign w_src   = reg_src_e'(decoded_reg_input_mux);

  // Write-back source select; the reserved encoding suppresses the write.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    w_write_en   = 1'b0;
    w_write_data = '0;
    if (w_state == CORE_UPDATE && decoded_reg_write_enable &&
        decoded_rd_address < 4'(GP_REG_LIMIT)) begin
      unique case (w_src)
        REG_SRC_ALU: begin w_write_en = 1'b1; w_write_data = alu_out;           end
        REG_SRC_LSU: begin w_write_en = 1'b1; w_write_data = lsu_out;           end
        REG_SRC_IMM: begin w_write_en = 1'b1; w_write_data = decoded_immediate; end
        default:     begin w_write_en = 1'b0; w_write_data = '0;                end
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is reset explicitly because special registers must
      // hold their constants and no pre-reset data may leak out.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_regs[REG_BLOCK_DIM] <= DATA_BITS'(THREADS_PER_BLOCK);
      r_regs[REG_THREAD_ID] <= DATA_BITS'(THREAD_ID);
      r_rs <= '0;
      r_rt <= '0;
    end else if (enable) begin
      r_regs[REG_BLOCK_ID] <= DATA_BITS'(block_id);
      if (w_state == CORE_REQUEST) begin
        r_rs <= r_regs[decoded_rs_address];
        r_rt <= r_regs[decoded_rt_address];
      end
      if (w_write_en) r_regs[decoded_rd_address] <= w_write_data;
    end
  end

  assign rs = r_rs;
  assign rt = r_rt;

endmodule : thread_register_file

// File: tb/tb_thread_register_file.sv
// Self-checking bench for thread_register_file (THREAD_ID=2, block dim 4):
// table-driven instructions plus hand-written block-id, disable and reset cases.
module tb_thread_register_file;
  import gpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] block_id;
  logic [2:0] core_state;
  logic [3:0] rd_a, rs_a, rt_a;
  logic       we;
  logic [1:0] mux;
  logic [7:0] imm, alu, lsu;
  logic [7:0] rs, rt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    logic [3:0] rs_a, rt_a;
    logic       we;
    logic [3:0] rd;
    logic [1:0] mux;
    logic [7:0] imm, alu, lsu;
    logic [7:0] exp_rs, exp_rt;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] rs, rt;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  thread_register_file #(
    .THREADS_PER_BLOCK(4),
    .THREAD_ID        (2),
    .DATA_BITS        (8)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .block_id                (block_id),
    .core_state              (core_state),
    .decoded_rd_address      (rd_a),
    .decoded_rs_address      (rs_a),
    .decoded_rt_address      (rt_a),
    .decoded_reg_write_enable(we),
    .decoded_reg_input_mux   (mux),
    .decoded_immediate       (imm),
    .alu_out                 (alu),
    .lsu_out                 (lsu),
    .rs                      (rs),
    .rt                      (rt)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Drive a state, clock once, and return at the following falling edge.
  task automatic step(input logic [2:0] st);
    core_state = st;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_and_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 8'h01, 8'h00);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_rs"}, rs, e.rs);
      check({e.name, "_rt"}, rt, e.rt);
    end
  endtask

  // One full instruction; operands are checked after REQUEST and again after UPDATE.
  task automatic run_instr(input vec_t v);
    exp_t e;
    rs_a = v.rs_a; rt_a = v.rt_a; we = v.we; rd_a = v.rd;
    mux = v.mux; imm = v.imm; alu = v.alu; lsu = v.lsu;
    step(CORE_FETCH);
    step(CORE_DECODE);
    e.name = v.name; e.rs = v.exp_rs; e.rt = v.exp_rt;
    sb_q.push_back(e);
    step(CORE_REQUEST);
    pop_and_check();
    step(CORE_WAIT);
    step(CORE_EXECUTE);
    e.name = {v.name, "_hold"};
    sb_q.push_back(e);
    step(CORE_UPDATE);
    pop_and_check();
    we = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    //         name        rs     rt     we    rd     mux    imm    alu    lsu    rs     rt
    vecs[0] = '{"dim_tid", 4'd14, 4'd15, 1'b0, 4'd0,  2'b00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h02};
    vecs[1] = '{"gp_zero", 4'd0,  4'd12, 1'b1, 4'd3,  2'b10, 8'h2A, 8'hEE, 8'hDD, 8'h00, 8'h00};
    vecs[2] = '{"imm_r3",  4'd3,  4'd3,  1'b1, 4'd3,  2'b00, 8'hEE, 8'h07, 8'hDD, 8'h2A, 8'h2A};
    vecs[3] = '{"alu_r3",  4'd3,  4'd0,  1'b1, 4'd7,  2'b01, 8'hEE, 8'hCC, 8'hF0, 8'h07, 8'h00};
    vecs[4] = '{"lsu_r7",  4'd7,  4'd3,  1'b1, 4'd15, 2'b10, 8'h55, 8'hCC, 8'hDD, 8'hF0, 8'h07};
    vecs[5] = '{"ro_r15",  4'd15, 4'd7,  1'b1, 4'd5,  2'b10, 8'h66, 8'hCC, 8'hDD, 8'h02, 8'hF0};
    vecs[6] = '{"imm_r5",  4'd5,  4'd1,  1'b1, 4'd5,  2'b11, 8'h77, 8'h77, 8'h77, 8'h66, 8'h00};
    vecs[7] = '{"rsvd_r5", 4'd5,  4'd15, 1'b1, 4'd12, 2'b00, 8'h00, 8'hC3, 8'h00, 8'h66, 8'h02};
    vecs[8] = '{"r12_blk", 4'd12, 4'd13, 1'b0, 4'd4,  2'b10, 8'h99, 8'h99, 8'h99, 8'hC3, 8'h00};
    vecs[9] = '{"no_we",   4'd4,  4'd12, 1'b0, 4'd0,  2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC3};

    reset = 1'b1; enable = 1'b1; block_id = 8'h00;
    rd_a = '0; rs_a = '0; rt_a = '0; we = 1'b0; mux = '0;
    imm = '0; alu = '0; lsu = '0; core_state = CORE_IDLE;
    @(negedge clk);
    step(CORE_IDLE);
    step(CORE_IDLE);
    reset = 1'b0;
    check("reset_rs", rs, 8'h00);
    check("reset_rt", rt, 8'h00);

    foreach (vecs[i]) run_instr(vecs[i]);

    // Block id refresh: one IDLE cycle is enough; writes to R13 are dropped.
    block_id = 8'h09;
    step(CORE_IDLE);
    run_instr('{"blk_id",  4'd13, 4'd14, 1'b1, 4'd13, 2'b10, 8'h11, 8'h11, 8'h11, 8'h09, 8'h04});
    run_instr('{"blk_ro",  4'd13, 4'd12, 1'b0, 4'd0,  2'b00, 8'h00, 8'h00, 8'h00, 8'h09, 8'hC3});

    // Disabled thread: a full instruction with a write changes nothing.
    enable = 1'b0;
    block_id = 8'h05;
    run_instr('{"dis",     4'd0,  4'd1,  1'b1, 4'd4,  2'b10, 8'h33, 8'h33, 8'h33, 8'h09, 8'hC3});
    // Re-enable straight into REQUEST: the read sees R13 from before the gap.
    enable = 1'b1;
    block_id = 8'h09;
    rs_a = 4'd13; rt_a = 4'd4;
    sb_q.push_back('{"dis_r13", 8'h09, 8'h00});
    step(CORE_REQUEST);
    pop_and_check();
    step(CORE_WAIT);

    // Reset during EXECUTE/UPDATE aborts the pending write and clears rs/rt.
    run_instr('{"w_r6",    4'd0,  4'd0,  1'b1, 4'd6,  2'b10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00});
    rs_a = 4'd6; rt_a = 4'd6; rd_a = 4'd6; we = 1'b1; mux = 2'b10; imm = 8'h5A;
    step(CORE_FETCH);
    step(CORE_DECODE);
    sb_q.push_back('{"r6_pre", 8'h10, 8'h10});
    step(CORE_REQUEST);
    pop_and_check();
    step(CORE_WAIT);
    reset = 1'b1;
    step(CORE_EXECUTE);
    step(CORE_UPDATE);
    reset = 1'b0;
    we = 1'b0;
    check("rst_mid_rs", rs, 8'h00);
    check("rst_mid_rt", rt, 8'h00);
    run_instr('{"post_rst", 4'd6, 4'd15, 1'b0, 4'd0,  2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02});
    run_instr('{"post_gp",  4'd3, 4'd14, 1'b0, 4'd0,  2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04});

    if (sb_q.size() != 0) check("scoreboard_leftover", 8'(sb_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_thread_register_file
